vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y position counters,
// registered sync/blank decode aligned with the position, and a frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HR      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VR      = 2,
    parameter int VB      = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CW      = 10,
    parameter int FW      = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic [FW-1:0] frame_cnt
);

    localparam int HTOT = HD + HF + HR + HB;
    localparam int VTOT = VD + VF + VR + VB;
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(HTOT - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(VTOT - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(HD);
    localparam logic [CW-1:0] V_ACT    = CW'(VD);
    localparam logic [CW-1:0] HS_FIRST = CW'(HD + HF);
    localparam logic [CW-1:0] HS_LAST  = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(VD + VF);
    localparam logic [CW-1:0] VS_LAST  = CW'(VD + VF + VR - 1);

    logic [DW-1:0] div_q;
    logic          tick_q;
    logic          ls_q;
    logic          fs_q;
    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;

    // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        x_wrap = (x == X_LAST);
        y_wrap = (y == Y_LAST);
        x_nxt  = x_wrap ? '0 : x + CW'(1);
        y_nxt  = y;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : y + CW'(1);
        end
    end

    // Decode is computed from the next position so the registered outputs
    // change on the same edge as x/y and never lag them.
    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            video_on  <= 1'b0;
            vblank    <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
        end else if (en) begin
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            tick_q <= (div_q == DIV_LAST);
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            if (tick_q) begin
                x        <= x_nxt;
                y        <= y_nxt;
                ls_q     <= x_wrap;
                fs_q     <= x_wrap && y_wrap;
                video_on <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
                vblank   <= (y_nxt >= V_ACT);
                hsync    <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
                vsync    <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
                if (x_wrap && y_wrap) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // Strobes are held through a freeze and masked by en, so a pulse pending
    // when en drops is shown again on resume instead of being lost.
    assign p_tick      = tick_q & en;
    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three parameter sets compared every
// cycle against an arithmetic model driven by the count of enabled clock edges.
module tb_vga_timing_gen;

    typedef struct packed {
        int d, hd, hf, hr, hb, vd, vf, vr, vb, fw;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        int x, y, fc;
        bit p_tick, line_start, frame_start, video_on, hsync, vsync, vblank;
    } obs_t;

    localparam cfg_t CFG_A = '{d:4, hd:640, hf:16, hr:96, hb:48, vd:480, vf:10, vr:2, vb:33,
                               fw:8, hp:1'b0, vp:1'b0};
    localparam cfg_t CFG_B = '{d:1, hd:4, hf:1, hr:2, hb:1, vd:3, vf:1, vr:1, vb:1,
                               fw:2, hp:1'b1, vp:1'b1};
    localparam cfg_t CFG_C = '{d:3, hd:5, hf:2, hr:3, hb:2, vd:4, vf:1, vr:2, vb:1,
                               fw:8, hp:1'b0, vp:1'b0};

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic en_a, en_b, en_c;

    logic       p_tick_a, video_on_a, hsync_a, vsync_a, line_start_a, frame_start_a, vblank_a;
    logic [9:0] x_a, y_a;
    logic [7:0] frame_cnt_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, line_start_b, frame_start_b, vblank_b;
    logic [3:0] x_b, y_b;
    logic [1:0] frame_cnt_b;
    logic       p_tick_c, video_on_c, hsync_c, vsync_c, line_start_c, frame_start_c, vblank_c;
    logic [3:0] x_c, y_c;
    logic [7:0] frame_cnt_c;

    int n_checks = 0;
    int n_pass   = 0;

    longint e_a = 0, e_b = 0, e_c = 0;

    always #5 sys_clk = ~sys_clk;

    vga_timing_gen u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en_a), .p_tick(p_tick_a),
        .x(x_a), .y(y_a), .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .vblank(vblank_a),
        .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .HD(4), .HF(1), .HR(2), .HB(1), .VD(3), .VF(1), .VR(1), .VB(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FW(2)
    ) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en_b), .p_tick(p_tick_b),
        .x(x_b), .y(y_b), .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .vblank(vblank_b),
        .frame_cnt(frame_cnt_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .HD(5), .HF(2), .HR(3), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(8)
    ) u_dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en_c), .p_tick(p_tick_c),
        .x(x_c), .y(y_c), .video_on(video_on_c), .hsync(hsync_c), .vsync(vsync_c),
        .line_start(line_start_c), .frame_start(frame_start_c), .vblank(vblank_c),
        .frame_cnt(frame_cnt_c)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Pixel n = completed pixel advances; one advance happens on each enabled
    // edge that follows a pixel strobe, i.e. n = (e-1)/CLK_DIV for e enabled edges.
    function automatic obs_t model(input cfg_t c, input longint e, input logic en);
        obs_t   o;
        longint n, ht, vt, xx, yy;
        bit     tick, adv;
        ht   = longint'(c.hd + c.hf + c.hr + c.hb);
        vt   = longint'(c.vd + c.vf + c.vr + c.vb);
        n    = (e == 0) ? 0 : (e - 1) / c.d;
        xx   = n % ht;
        yy   = (n / ht) % vt;
        tick = (e > 0) && (e % c.d == 0);
        adv  = (e > 1) && ((e - 1) % c.d == 0);
        o.x           = int'(xx);
        o.y           = int'(yy);
        o.fc          = int'((n / (ht * vt)) % (64'd1 << c.fw));
        o.p_tick      = en && tick;
        o.line_start  = en && adv && (xx == 0);
        o.frame_start = o.line_start && (yy == 0);
        if (n == 0) begin
            o.video_on = 1'b0;
            o.vblank   = 1'b0;
            o.hsync    = !c.hp;
            o.vsync    = !c.vp;
        end else begin
            o.video_on = (xx < c.hd) && (yy < c.vd);
            o.vblank   = (yy >= c.vd);
            o.hsync    = (xx >= c.hd + c.hf && xx < c.hd + c.hf + c.hr) ? c.hp : !c.hp;
            o.vsync    = (yy >= c.vd + c.vf && yy < c.vd + c.vf + c.vr) ? c.vp : !c.vp;
        end
        return o;
    endfunction

    function automatic obs_t mk(input int xx, yy, fc, input logic p, ls, fs, vo, hs, vs, vb);
        obs_t o;
        o.x = xx; o.y = yy; o.fc = fc;
        o.p_tick = p; o.line_start = ls; o.frame_start = fs;
        o.video_on = vo; o.hsync = hs; o.vsync = vs; o.vblank = vb;
        return o;
    endfunction

    task automatic compare(input string p, input obs_t o, input obs_t m);
        check({p, "_x"},           o.x,           m.x);
        check({p, "_y"},           o.y,           m.y);
        check({p, "_frame_cnt"},   o.fc,          m.fc);
        check({p, "_p_tick"},      o.p_tick,      m.p_tick);
        check({p, "_line_start"},  o.line_start,  m.line_start);
        check({p, "_frame_start"}, o.frame_start, m.frame_start);
        check({p, "_video_on"},    o.video_on,    m.video_on);
        check({p, "_hsync"},       o.hsync,       m.hsync);
        check({p, "_vsync"},       o.vsync,       m.vsync);
        check({p, "_vblank"},      o.vblank,      m.vblank);
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            e_a <= 0; e_b <= 0; e_c <= 0;
        end else begin
            if (en_a) e_a <= e_a + 1;
            if (en_b) e_b <= e_b + 1;
            if (en_c) e_c <= e_c + 1;
        end
    end

    always @(negedge sys_clk) begin
        compare("a", mk(int'(x_a), int'(y_a), int'(frame_cnt_a), p_tick_a, line_start_a,
                        frame_start_a, video_on_a, hsync_a, vsync_a, vblank_a),
                model(CFG_A, e_a, en_a));
        compare("b", mk(int'(x_b), int'(y_b), int'(frame_cnt_b), p_tick_b, line_start_b,
                        frame_start_b, video_on_b, hsync_b, vsync_b, vblank_b),
                model(CFG_B, e_b, en_b));
        compare("c", mk(int'(x_c), int'(y_c), int'(frame_cnt_c), p_tick_c, line_start_c,
                        frame_start_c, video_on_c, hsync_c, vsync_c, vblank_c),
                model(CFG_C, e_c, en_c));
    end

    task automatic cyc();
        @(negedge sys_clk);
        #1;
        en_c = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pulses;
        int last;
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) cyc();
        sys_rst_n = 1'b1;

        // First strobe on the default divider lands CLK_DIV cycles after release.
        k = 0;
        do begin cyc(); k++; end while (!p_tick_a && k < 20);
        check("a_first_tick_latency", k, 4);

        // Small raster: 48-cycle frames and a 2-bit frame counter wrapping to 0.
        pulses = 0; last = 0; k = 0;
        while (pulses < 4 && k < 400) begin
            cyc();
            k++;
            if (frame_start_b) begin
                pulses++;
                if (pulses > 1) check("b_frame_period", k - last, 48);
                last = k;
                if (pulses == 3) check("b_fc_after_3", int'(frame_cnt_b), 3);
                if (pulses == 4) check("b_fc_wrap", int'(frame_cnt_b), 0);
            end
        end
        check("b_frame_starts_seen", pulses, 4);

        // Freeze the default raster at x=100, y=10 for 37 cycles.
        k = 0;
        while (!(x_a == 10'd100 && y_a == 10'd10) && k < 40000) begin cyc(); k++; end
        check("a_reach_freeze_x", int'(x_a), 100);
        check("a_reach_freeze_y", int'(y_a), 10);
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            cyc();
            check("a_frozen_x", int'(x_a), 100);
            check("a_frozen_y", int'(y_a), 10);
            check("a_frozen_p_tick", int'(p_tick_a), 0);
            check("a_frozen_line_start", int'(line_start_a), 0);
        end
        en_a = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (!p_tick_a && k < 20);
        check("a_resume_tick_latency", k, 3);

        // Reset in mid-frame.
        k = 0;
        while (!(x_a == 10'd700 && y_a == 10'd11) && k < 8000) begin cyc(); k++; end
        check("a_reach_reset_x", int'(x_a), 700);
        sys_rst_n = 1'b0;
        #2;
        check("a_rst_x", int'(x_a), 0);
        check("a_rst_y", int'(y_a), 0);
        check("a_rst_frame_cnt", int'(frame_cnt_a), 0);
        check("a_rst_p_tick", int'(p_tick_a), 0);
        check("a_rst_line_start", int'(line_start_a), 0);
        check("a_rst_frame_start", int'(frame_start_a), 0);
        check("a_rst_video_on", int'(video_on_a), 0);
        check("a_rst_vblank", int'(vblank_a), 0);
        check("a_rst_hsync", int'(hsync_a), 1);
        check("a_rst_vsync", int'(vsync_a), 1);
        repeat (3) cyc();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin cyc(); k++; end while (!p_tick_a && k < 20);
            check("a_post_reset_x_at_tick", int'(x_a), i);
        end

        // Random enable on all sets; the per-cycle comparison does the checking.
        repeat (3000) begin
            en_a = 1'($urandom_range(0, 1));
            en_b = ($urandom_range(0, 4) != 0);
            cyc();
        end
        check("c_frames_completed_ge3", int'(frame_cnt_c >= 8'd3), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
